// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: access size codes,
// FSM states and the round-robin grant marker.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        MSIZE_B  = 3'b000,
        MSIZE_H  = 3'b001,
        MSIZE_W  = 3'b010,
        MSIZE_D  = 3'b011,
        MSIZE_BU = 3'b100,
        MSIZE_HU = 3'b101,
        MSIZE_WU = 3'b110
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter sharing one memory bus between instruction fetch
// and data access. One transaction at a time; every output is a flop.
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// I_BUSY | fetch outstanding on the bus, waiting for bus_done
// D_BUSY | data access outstanding on the bus, waiting for bus_done
// RESP   | one-cycle ok pulse to the served requester, no arbitration
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_ok,
    output logic [31:0]         iresp_data,
    input  logic                dreq_valid,
    input  logic                dreq_we,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    output logic                dresp_ok,
    output logic [DATA_W-1:0]   dresp_data,
    output logic                bus_valid,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [2:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_strobe,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_done,
    input  logic [DATA_W-1:0]   bus_rdata
);

    arb_state_t          state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [2:0]          bus_size_q, bus_size_d;
    logic [DATA_W/8-1:0] bus_strobe_q, bus_strobe_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                iresp_ok_q, iresp_ok_d;
    logic [31:0]         iresp_data_q, iresp_data_d;
    logic                dresp_ok_q, dresp_ok_d;
    logic [DATA_W-1:0]   dresp_data_q, dresp_data_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_size_d   = bus_size_q;
        bus_strobe_d = bus_strobe_q;
        bus_wdata_d  = bus_wdata_q;
        iresp_ok_d   = 1'b0;
        iresp_data_d = iresp_data_q;
        dresp_ok_d   = 1'b0;
        dresp_data_d = dresp_data_q;

        case (state_q)
            ST_IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (ireq_valid && (!dreq_valid || last_grant_q == GRANT_D)) begin
                    state_d      = ST_I_BUSY;
                    last_grant_d = GRANT_I;
                    bus_valid_d  = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = ireq_addr;
                    bus_size_d   = MSIZE_W;
                    bus_strobe_d = '0;
                    bus_wdata_d  = '0;
                end else if (dreq_valid) begin
                    state_d      = ST_D_BUSY;
                    last_grant_d = GRANT_D;
                    bus_valid_d  = 1'b1;
                    bus_we_d     = dreq_we;
                    bus_addr_d   = dreq_addr;
                    bus_size_d   = dreq_size;
                    bus_strobe_d = dreq_strobe;
                    bus_wdata_d  = dreq_wdata;
                end
            end
            ST_I_BUSY: begin
                if (bus_done) begin
                    state_d      = ST_RESP;
                    bus_valid_d  = 1'b0;
                    iresp_ok_d   = 1'b1;
                    // Latched address keeps lane selection valid even if the fetch dropped.
                    iresp_data_d = bus_addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
                end
            end
            ST_D_BUSY: begin
                if (bus_done) begin
                    state_d      = ST_RESP;
                    bus_valid_d  = 1'b0;
                    dresp_ok_d   = 1'b1;
                    dresp_data_d = bus_rdata;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_size_q   <= '0;
            bus_strobe_q <= '0;
            bus_wdata_q  <= '0;
            iresp_ok_q   <= 1'b0;
            iresp_data_q <= '0;
            dresp_ok_q   <= 1'b0;
            dresp_data_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_size_q   <= bus_size_d;
            bus_strobe_q <= bus_strobe_d;
            bus_wdata_q  <= bus_wdata_d;
            iresp_ok_q   <= iresp_ok_d;
            iresp_data_q <= iresp_data_d;
            dresp_ok_q   <= dresp_ok_d;
            dresp_data_q <= dresp_data_d;
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_size   = bus_size_q;
    assign bus_strobe = bus_strobe_q;
    assign bus_wdata  = bus_wdata_q;
    assign iresp_ok   = iresp_ok_q;
    assign iresp_data = iresp_data_q;
    assign dresp_ok   = dresp_ok_q;
    assign dresp_data = dresp_data_q;

endmodule
